// File: rtl/mdu_pkg.sv
// Shared types and opcode helpers for the iterative multiply/divide unit.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'b000,
      MDU_MULH   = 3'b001,
      MDU_MULHSU = 3'b010,
      MDU_MULHU  = 3'b011,
      MDU_DIV    = 3'b100,
      MDU_DIVU   = 3'b101,
      MDU_REM    = 3'b110,
      MDU_REMU   = 3'b111
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DONE
   } mdu_state_e;

   function automatic logic is_div(input mdu_op_e op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
   endfunction

   function automatic logic is_signed_b(input mdu_op_e op);
      return op inside {MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM};
   endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on magnitudes; purely combinational.
// Requires rem_in < divisor, so the trial value always fits in XLEN+1 bits.
module mdu_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_in,
   input  logic [XLEN-1:0] divisor,
   input  logic            dividend_bit,
   output logic [XLEN-1:0] rem_out,
   output logic            quo_bit
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   always_comb begin
      trial   = {rem_in, dividend_bit};
      diff    = trial - {1'b0, divisor};
      // Top bit of the difference is set exactly when the subtraction borrowed.
      quo_bit = ~diff[XLEN];
      rem_out = quo_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
   end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RV32M mul/div: XLEN+1 cycle latency (1 for div-by-zero/overflow), result held until i_ready.
// Optional MDU_EARLY_OUT_EN: multiply exits BUSY once the remaining multiplier bits are zero.
module mdu_iter
   import mdu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_mdu_op,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_mdu_data,
   output logic            o_div_zero
);

   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state, state_nxt;
   mdu_op_e           op, op_in;
   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   b_mag;
   logic              neg_res;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   data;
   logic              div_zero;

   logic              sign_a, sign_b, neg_in;
   logic [XLEN-1:0]   a_mag, b_mag_in, fast_data;
   logic              div_zero_in, ovf_in, fast_in;

   logic [XLEN-1:0]   addend;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_nxt, mul_fin, div_nxt, step_nxt, prod;
   logic [XLEN-1:0]   rem_out, res_mag, res;
   logic              quo_bit, early, last;
   logic              accept, finish;
`ifdef MDU_EARLY_OUT_EN
   logic [CNT_W-1:0]  rem_steps;
`endif

   // Request decode: magnitudes, result sign and the single-cycle fast paths.
   always_comb begin
      op_in       = mdu_op_e'(i_mdu_op);
      sign_a      = is_signed_a(op_in) && i_op_a[XLEN-1];
      sign_b      = is_signed_b(op_in) && i_op_b[XLEN-1];
      a_mag       = sign_a ? -i_op_a : i_op_a;
      b_mag_in    = sign_b ? -i_op_b : i_op_b;
      div_zero_in = is_div(op_in) && (i_op_b == '0);
      ovf_in      = (op_in == MDU_DIV || op_in == MDU_REM) &&
                    (i_op_a == MIN_NEG) && (i_op_b == '1);
      fast_in     = div_zero_in || ovf_in;
      if (div_zero_in) fast_data = op_in[1] ? i_op_a : '1;
      else             fast_data = op_in[1] ? '0 : i_op_a;
      if (is_div(op_in) && op_in[1]) neg_in = sign_a;
      else                           neg_in = sign_a ^ sign_b;
   end

   mdu_div_step #(.XLEN(XLEN)) u_div_step (
      .rem_in       (acc[2*XLEN-1:XLEN]),
      .divisor      (b_mag),
      .dividend_bit (acc[XLEN-1]),
      .rem_out      (rem_out),
      .quo_bit      (quo_bit)
   );

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      addend  = acc[0] ? b_mag : '0;
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, addend};
      mul_nxt = {mul_sum, acc[XLEN-1:1]};
      div_nxt = {rem_out, acc[XLEN-2:0], quo_bit};
`ifdef MDU_EARLY_OUT_EN
      rem_steps = cnt - CNT_W'(1);
      early     = !is_div(op) && ((mul_nxt & ~({(2*XLEN){1'b1}} << rem_steps)) == '0);
      mul_fin   = mul_nxt >> rem_steps;
`else
      early     = 1'b0;
      mul_fin   = mul_nxt;
`endif
      last     = (cnt == CNT_W'(1)) || early;
      step_nxt = is_div(op) ? div_nxt : mul_fin;
      prod     = neg_res ? -step_nxt : step_nxt;
      res_mag  = op[1] ? step_nxt[2*XLEN-1:XLEN] : step_nxt[XLEN-1:0];
      if (is_div(op)) res = neg_res ? -res_mag : res_mag;
      else            res = (op == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      finish    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (i_valid) begin
               accept    = 1'b1;
               state_nxt = fast_in ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (i_flush) begin
               state_nxt = ST_IDLE;
            end else if (last) begin
               finish    = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_flush || i_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state    <= ST_IDLE;
         op       <= MDU_MUL;
         acc      <= '0;
         b_mag    <= '0;
         neg_res  <= 1'b0;
         cnt      <= '0;
         data     <= '0;
         div_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op       <= op_in;
            acc      <= {{XLEN{1'b0}}, a_mag};
            b_mag    <= b_mag_in;
            neg_res  <= neg_in;
            cnt      <= CNT_W'(XLEN);
            div_zero <= div_zero_in;
            if (fast_in) data <= fast_data;
         end
         if (state == ST_BUSY) begin
            acc <= step_nxt;
            cnt <= cnt - CNT_W'(1);
            if (finish) data <= res;
         end
      end
   end

   assign o_ready    = (state == ST_IDLE);
   assign o_valid    = (state == ST_DONE);
   assign o_mdu_data = data;
   assign o_div_zero = div_zero;

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed bench for mdu_iter against an arithmetic reference model.
module tb_mdu_iter;

   localparam int XLEN = 32;

   logic            i_clk = 1'b0;
   logic            i_reset = 1'b1;
   logic            i_valid = 1'b0;
   logic            i_flush = 1'b0;
   logic            i_ready = 1'b0;
   logic [2:0]      i_mdu_op = 3'd0;
   logic [XLEN-1:0] i_op_a = '0;
   logic [XLEN-1:0] i_op_b = '0;
   logic            o_ready, o_valid, o_div_zero;
   logic [XLEN-1:0] o_mdu_data;

   int n_chk  = 0;
   int n_pass = 0;
   logic [31:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   mdu_iter #(.XLEN(XLEN)) dut (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_mdu_op   (i_mdu_op),
      .i_op_a     (i_op_a),
      .i_op_b     (i_op_b),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_mdu_data (o_mdu_data),
      .o_div_zero (o_div_zero)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
   endtask

   // Returns {div_zero, result} straight from the RV32M arithmetic rules.
   function automatic logic [32:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] t;
      logic [31:0] r;
      logic        dz;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      dz = 1'b0;
      t  = '0;
      r  = '0;
      case (op)
         3'd0: begin t = sa * sb; r = t[31:0];  end
         3'd1: begin t = sa * sb; r = t[63:32]; end
         3'd2: begin t = sa * ub; r = t[63:32]; end
         3'd3: begin t = ua * ub; r = t[63:32]; end
         3'd4: begin
            if (b == 0) begin r = '1; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else begin t = sa / sb; r = t[31:0]; end
         end
         3'd5: begin
            if (b == 0) begin r = '1; dz = 1'b1; end
            else begin t = ua / ub; r = t[31:0]; end
         end
         3'd6: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
            else begin t = sa % sb; r = t[31:0]; end
         end
         default: begin
            if (b == 0) begin r = a; dz = 1'b1; end
            else begin t = ua % ub; r = t[31:0]; end
         end
      endcase
      return {dz, r};
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 3))
         0, 1:    return $urandom;
         2:       return $urandom_range(0, 15);
         default: return specials[$urandom_range(0, 4)];
      endcase
   endfunction

   // Issue one request, measure latency, hold the result for 'hold' cycles, then accept it.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int hold);
      logic [32:0] want;
      logic        fast;
      int          lat;
      int          w;
      want = ref_mdu(op, a, b);
      fast = op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      @(negedge i_clk);
      i_valid = 1'b1; i_mdu_op = op; i_op_a = a; i_op_b = b;
      w = 0;
      while (!o_ready && w < 100) begin @(negedge i_clk); w++; end
      check({tag, " accept"}, o_ready, 1);
      @(posedge i_clk);
      #1;
      i_valid = 1'b0; i_op_a = $urandom; i_op_b = $urandom;
      lat = 1;
      @(negedge i_clk);
      while (!o_valid && lat < 200) begin @(negedge i_clk); lat++; end
      check({tag, " data"}, o_mdu_data, want[31:0]);
      check({tag, " dz"}, o_div_zero, want[32]);
`ifdef MDU_EARLY_OUT_EN
      if (fast || op[2]) check({tag, " lat"}, lat, fast ? 1 : 33);
      else check({tag, " lat range"}, (lat >= 2 && lat <= 33), 1);
`else
      check({tag, " lat"}, lat, fast ? 1 : 33);
`endif
      for (int k = 0; k < hold; k++) begin
         i_valid = 1'b1;
         @(negedge i_clk);
         check({tag, " hold"}, {o_valid, o_ready, o_div_zero, o_mdu_data}, {1'b1, 1'b0, want});
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge i_clk);
      #1 i_ready = 1'b0;
      @(negedge i_clk);
      check({tag, " release"}, {o_valid, o_ready}, 2'b01);
   endtask

   initial begin
      logic seen;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b0;
      check("reset", {o_valid, o_ready, o_div_zero, o_mdu_data}, {1'b0, 1'b1, 1'b0, 32'h0});

      run_op("mul",      3'd0, 32'd7,         32'hFFFF_FFFD, 0);
      run_op("mulh",     3'd1, 32'h8000_0000, 32'h8000_0000, 0);
      run_op("mulhu",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op("mulhsu",   3'd2, 32'hFFFF_FFFF, 32'd2,         0);
      run_op("div",      3'd4, 32'hFFFF_FFF9, 32'd2,         0);
      run_op("rem",      3'd6, 32'hFFFF_FFF9, 32'd2,         0);
      run_op("divu",     3'd5, 32'd100,       32'd7,         0);
      run_op("remu",     3'd7, 32'd100,       32'd7,         0);
      run_op("divu_z",   3'd5, 32'd5,         32'd0,         0);
      run_op("rem_z",    3'd6, 32'd5,         32'd0,         0);
      run_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      run_op("bp_div",   3'd4, 32'hFFFF_FFF9, 32'd2,         5);
      run_op("bp_z",     3'd5, 32'd9,         32'd0,         5);
      run_op("b2b_mul",  3'd0, 32'd3,         32'd4,         0);
      run_op("b2b_div",  3'd4, 32'd12,        32'd4,         0);

      // Flush ten cycles into a multiply: the result must never appear.
      @(negedge i_clk);
      i_valid = 1'b1; i_mdu_op = 3'd0; i_op_a = $urandom; i_op_b = $urandom;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      repeat (10) @(negedge i_clk);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1 i_flush = 1'b0;
      @(negedge i_clk);
      check("flush_busy", {o_valid, o_ready}, 2'b01);
      seen = 1'b0;
      repeat (40) begin @(negedge i_clk); seen |= o_valid; end
      check("flush_no_valid", seen, 0);

      // Flush while a fast-path result is pending.
      i_valid = 1'b1; i_mdu_op = 3'd5; i_op_a = 32'd5; i_op_b = 32'd0;
      @(posedge i_clk);
      #1 i_valid = 1'b0;
      @(negedge i_clk);
      check("flush_done_pre", o_valid, 1);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1 i_flush = 1'b0;
      @(negedge i_clk);
      check("flush_done", {o_valid, o_ready}, 2'b01);

      // Flush in IDLE does not block acceptance.
      i_flush = 1'b1; i_valid = 1'b1; i_mdu_op = 3'd3; i_op_a = $urandom; i_op_b = $urandom;
      @(posedge i_clk);
      #1 begin i_flush = 1'b0; i_valid = 1'b0; end
      @(negedge i_clk);
      check("flush_idle", {o_valid, o_ready}, 2'b00);

      // Reset mid-BUSY: stale 0xFFFFFFFF data from the div-by-zero must be cleared.
      repeat (5) @(negedge i_clk);
      i_reset = 1'b1;
      @(posedge i_clk);
      #1 i_reset = 1'b0;
      @(negedge i_clk);
      check("reset_busy", {o_valid, o_ready, o_div_zero, o_mdu_data}, {1'b0, 1'b1, 1'b0, 32'h0});

      // Reset beats a simultaneous request.
      i_reset = 1'b1; i_valid = 1'b1; i_mdu_op = 3'd5; i_op_a = 32'd1; i_op_b = 32'd0;
      @(posedge i_clk);
      #1 begin i_reset = 1'b0; i_valid = 1'b0; end
      @(negedge i_clk);
      check("reset_prio", {o_valid, o_ready}, 2'b01);

      for (int n = 0; n < 40; n++) begin
         logic [31:0] ra, rb;
         ra = pick();
         rb = pick();
         run_op("rand", 3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 2));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
